// File: rtl/net_adaptive_out_sched_if.sv
// Request/grant and downstream channel bundle for one ring output scheduler.
// master: requesters + downstream side; slave: the scheduler itself.
interface net_adaptive_out_sched_if #(
   parameter int p_msg_nbits      = 8,
   parameter int p_num_free_nbits = 2
);
   logic [2:0]                  in_val;
   logic [2:0]                  in_domain;
   logic [3*p_msg_nbits-1:0]    in_msg;
   logic [2:0]                  in_rdy;
   logic                        out_val;
   logic                        out_domain;
   logic [p_msg_nbits-1:0]      out_msg;
   logic                        credit_return;
   logic [p_num_free_nbits-1:0] num_free;
   logic                        credit_err;

   modport master (
      output in_val, in_domain, in_msg, credit_return,
      input  in_rdy, out_val, out_domain, out_msg, num_free, credit_err
   );

   modport slave (
      input  in_val, in_domain, in_msg, credit_return,
      output in_rdy, out_val, out_domain, out_msg, num_free, credit_err
   );
endinterface

// File: rtl/net_adaptive_out_sched.sv
// Round-robin output-channel scheduler with credit tracking and domain bubble.
// Ports: clk, reset (sync, active-high), bus (slave side of the scheduler bundle).
module net_adaptive_out_sched #(
   parameter int p_msg_nbits      = 8,
   parameter int p_credits        = 2,
   parameter int p_num_free_nbits = 2
) (
   input logic clk,
   input logic reset,
   net_adaptive_out_sched_if.slave bus
);
   localparam int c_cnt_nbits = 3;
   localparam logic [c_cnt_nbits-1:0] c_cnt_rst = c_cnt_nbits'(p_credits);
   localparam logic [c_cnt_nbits-1:0] c_nf_max =
      c_cnt_nbits'((1 << p_num_free_nbits) - 1);

   logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
   logic [1:0]             ptr_q, ptr_d;
   logic                   last_dom_q, last_dom_d;
   logic                   sent_q, sent_d;
   logic                   err_q, err_d;

   logic [1:0] p1, p2, win;
   logic       found, win_dom, grant;
   logic [p_msg_nbits-1:0] win_msg;

   // Winner selection in order (ptr+1)%3, (ptr+2)%3, ptr.
   always_comb begin
      p1    = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      p2    = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
      win   = 2'd0;
      found = 1'b0;
      if (bus.in_val[p1]) begin
         win   = p1;
         found = 1'b1;
      end else if (bus.in_val[p2]) begin
         win   = p2;
         found = 1'b1;
      end else if (bus.in_val[ptr_q]) begin
         win   = ptr_q;
         found = 1'b1;
      end
   end

   always_comb begin
      win_msg = '0;
      win_dom = 1'b0;
      case (win)
         2'd0: begin
            win_msg = bus.in_msg[0*p_msg_nbits +: p_msg_nbits];
            win_dom = bus.in_domain[0];
         end
         2'd1: begin
            win_msg = bus.in_msg[1*p_msg_nbits +: p_msg_nbits];
            win_dom = bus.in_domain[1];
         end
         2'd2: begin
            win_msg = bus.in_msg[2*p_msg_nbits +: p_msg_nbits];
            win_dom = bus.in_domain[2];
         end
         default: begin
            win_msg = '0;
            win_dom = 1'b0;
         end
      endcase
   end

   // A domain switch right after a send stalls the channel for one cycle;
   // the blocked winner is not replaced by another requester.
   always_comb begin
      grant = found && !reset && (cnt_q != '0) &&
              !(sent_q && (win_dom != last_dom_q));
   end

   always_comb begin
      bus.in_rdy     = grant ? 3'(3'b001 << win) : 3'b000;
      bus.out_val    = grant;
      bus.out_msg    = grant ? win_msg : '0;
      bus.out_domain = grant ? win_dom : 1'b0;
      bus.num_free   = (cnt_q > c_nf_max) ?
                       p_num_free_nbits'(c_nf_max) :
                       p_num_free_nbits'(cnt_q);
      bus.credit_err = err_q;
   end

   always_comb begin
      ptr_d      = ptr_q;
      last_dom_d = last_dom_q;
      sent_d     = grant;
      err_d      = err_q;
      cnt_d      = cnt_q - {2'b00, grant} + {2'b00, bus.credit_return};
      if (grant) begin
         ptr_d      = win;
         last_dom_d = win_dom;
      end
      // Return into a full counter: hold at max and flag the overflow.
      if (bus.credit_return && !grant && (cnt_q == c_cnt_rst)) begin
         cnt_d = cnt_q;
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= c_cnt_rst;
         ptr_q      <= 2'd2;
         last_dom_q <= 1'b0;
         sent_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         last_dom_q <= last_dom_d;
         sent_q     <= sent_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_net_adaptive_out_sched.sv
// Directed bench for net_adaptive_out_sched.
// Drives the master side of the bundle and checks grants, credits and flags.
module tb_net_adaptive_out_sched;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   net_adaptive_out_sched_if #(.p_msg_nbits(8), .p_num_free_nbits(2)) bus();

   net_adaptive_out_sched #(
      .p_msg_nbits(8),
      .p_credits(2),
      .p_num_free_nbits(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Look at outputs mid-cycle, then advance to just after the next edge.
   task automatic settle();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] d,
                        input logic cr);
      bus.in_val        = v;
      bus.in_domain     = d;
      bus.credit_return = cr;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(3'b000, 3'b000, 1'b0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] rdy,
                          input logic val, input logic [7:0] msg,
                          input logic dom, input logic [1:0] nf);
      chk({tag, ".rdy"}, 32'(bus.in_rdy), 32'(rdy));
      chk({tag, ".val"}, 32'(bus.out_val), 32'(val));
      chk({tag, ".msg"}, 32'(bus.out_msg), 32'(msg));
      chk({tag, ".dom"}, 32'(bus.out_domain), 32'(dom));
      chk({tag, ".nf"}, 32'(bus.num_free), 32'(nf));
   endtask

   initial begin
      reset = 1'b1;
      bus.in_msg = {8'hC2, 8'hB1, 8'hA0};
      drive(3'b111, 3'b000, 1'b0);
      tick();
      settle();
      chk_out("rst_hold", 3'b000, 1'b0, 8'h00, 1'b0, 2'd2);
      chk("rst_err", 32'(bus.credit_err), 32'd0);
      tick();

      // T1: drain two credits then stall
      reset = 1'b0;
      drive(3'b111, 3'b000, 1'b0);
      settle(); chk_out("t1c1", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2); tick();
      settle(); chk_out("t1c2", 3'b010, 1'b1, 8'hB1, 1'b0, 2'd1); tick();
      settle(); chk_out("t1c3", 3'b000, 1'b0, 8'h00, 1'b0, 2'd0); tick();

      // T2: credits kept full, round-robin rotation
      do_reset();
      drive(3'b111, 3'b000, 1'b1);
      settle(); chk_out("t2c1", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2); tick();
      settle(); chk_out("t2c2", 3'b010, 1'b1, 8'hB1, 1'b0, 2'd2); tick();
      settle(); chk_out("t2c3", 3'b100, 1'b1, 8'hC2, 1'b0, 2'd2); tick();
      settle(); chk_out("t2c4", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2);
      chk("t2err", 32'(bus.credit_err), 32'd0); tick();

      // T3: domain change bubble
      do_reset();
      drive(3'b001, 3'b000, 1'b0);
      settle(); chk_out("t3c1", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2); tick();
      drive(3'b100, 3'b100, 1'b0);
      settle(); chk_out("t3c2", 3'b000, 1'b0, 8'h00, 1'b0, 2'd1); tick();
      settle(); chk_out("t3c3", 3'b100, 1'b1, 8'hC2, 1'b1, 2'd1); tick();

      // T4: blocked winner not substituted
      do_reset();
      drive(3'b001, 3'b000, 1'b0);
      settle(); chk_out("t4c1", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2); tick();
      drive(3'b110, 3'b010, 1'b0);
      settle(); chk_out("t4c2", 3'b000, 1'b0, 8'h00, 1'b0, 2'd1); tick();
      settle(); chk_out("t4c3", 3'b010, 1'b1, 8'hB1, 1'b1, 2'd1); tick();

      // T5: return at zero credits
      do_reset();
      drive(3'b001, 3'b000, 1'b0);
      tick();
      tick();
      drive(3'b001, 3'b000, 1'b1);
      settle(); chk_out("t5c3", 3'b000, 1'b0, 8'h00, 1'b0, 2'd0); tick();
      drive(3'b001, 3'b000, 1'b0);
      settle(); chk_out("t5c4", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd1); tick();
      drive(3'b000, 3'b000, 1'b0);
      settle(); chk_out("t5c5", 3'b000, 1'b0, 8'h00, 1'b0, 2'd0); tick();

      // T6: overflow flag, then reset mid-stream
      do_reset();
      drive(3'b000, 3'b000, 1'b1);
      settle(); chk("t6err0", 32'(bus.credit_err), 32'd0); tick();
      drive(3'b000, 3'b000, 1'b0);
      settle(); chk("t6err1", 32'(bus.credit_err), 32'd1);
      chk("t6nf", 32'(bus.num_free), 32'd2); tick();
      drive(3'b111, 3'b000, 1'b0);
      settle(); chk_out("t6g", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2); tick();
      chk("t6sticky", 32'(bus.credit_err), 32'd1);
      reset = 1'b1;
      settle(); chk_out("t6rst", 3'b000, 1'b0, 8'h00, 1'b0, 2'd1); tick();
      reset = 1'b0;
      settle();
      chk_out("t6post", 3'b001, 1'b1, 8'hA0, 1'b0, 2'd2);
      chk("t6errclr", 32'(bus.credit_err), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
